// File: rtl/serv_fetch_pkg.sv
// Shared types and widths for the sequential instruction prefetch buffer.
package serv_fetch_pkg;

    localparam int FETCH_ADR_W = 30;
    localparam int INSN_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DRAIN = 2'd2
    } bus_state_t;

endpackage

// File: rtl/serv_fetch_buf_if.sv
// Word-addressed fetch handshake, used both for the core request and the Wishbone ibus.
interface serv_fetch_buf_if;

    logic                                  cyc;
    logic [serv_fetch_pkg::FETCH_ADR_W-1:0] adr;
    logic                                  ack;
    logic [serv_fetch_pkg::INSN_W-1:0]      rdt;

    modport master (output cyc, output adr, input ack, input rdt);
    modport slave  (input cyc, input adr, output ack, output rdt);

endinterface

// File: rtl/serv_fetch_fifo.sv
// Instruction word FIFO with push/pop/flush; only the pointers are reset.
module serv_fetch_fifo
    import serv_fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [INSN_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [INSN_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [PTR_W-1:0]  o_count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [INSN_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            mem_reg[wr_ptr_reg[IDX_W-1:0]] <= i_data;
        end
    end

    // A flush empties the FIFO by catching the read pointer up to the write pointer.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (i_flush) begin
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (i_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (i_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    assign o_data  = mem_reg[rd_ptr_reg[IDX_W-1:0]];
    assign o_count = wr_ptr_reg - rd_ptr_reg;
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == PTR_W'(DEPTH));

endmodule

// File: rtl/serv_fetch_buf.sv
// Sequential instruction prefetch buffer between the core fetch request and the Wishbone ibus.
// Optional hit/miss counters are enabled by defining SERV_FETCH_BUF_PERF_EN.
module serv_fetch_buf
    import serv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             i_rst_n,
    serv_fetch_buf_if.slave  core,
    serv_fetch_buf_if.master wb
`ifdef SERV_FETCH_BUF_PERF_EN
    ,
    output logic [15:0]      o_hit_cnt,
    output logic [15:0]      o_miss_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [FETCH_ADR_W-1:0] ADR_ONE = FETCH_ADR_W'(1);

    bus_state_t             state_reg, state_next;
    logic                   wb_cyc_reg, wb_cyc_next;
    logic [FETCH_ADR_W-1:0] wb_adr_reg, wb_adr_next;
    logic [FETCH_ADR_W-1:0] head_adr_reg, head_adr_next;
    logic [FETCH_ADR_W-1:0] pf_adr_reg, pf_adr_next;
    logic                   ack_reg;
    logic [INSN_W-1:0]      rdt_reg;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CNT_W-1:0]       fifo_count;
    logic [INSN_W-1:0]      fifo_head;

    logic eval, hit, is_wait, miss, push;

    // The request is stale while the previous ack is on the outputs.
    always_comb begin
        eval    = core.cyc && !ack_reg;
        hit     = eval && !fifo_empty && (head_adr_reg == core.adr);
        is_wait = eval && fifo_empty && (state_reg == BUS) && (wb_adr_reg == core.adr);
        miss    = eval && !hit && !is_wait;
    end

    always_comb begin
        state_next    = state_reg;
        wb_cyc_next   = wb_cyc_reg;
        wb_adr_next   = wb_adr_reg;
        head_adr_next = head_adr_reg;
        pf_adr_next   = miss ? core.adr : pf_adr_reg;
        push          = 1'b0;

        if (miss) begin
            head_adr_next = core.adr;
        end else if (hit) begin
            head_adr_next = head_adr_reg + ADR_ONE;
        end

        unique case (state_reg)
            // A miss leaves the FIFO empty, so it may issue to the new target at once.
            IDLE: begin
                if (miss || (fifo_count < CNT_W'(DEPTH))) begin
                    wb_cyc_next = 1'b1;
                    wb_adr_next = pf_adr_next;
                    pf_adr_next = pf_adr_next + ADR_ONE;
                    state_next  = BUS;
                end
            end
            BUS: begin
                if (wb.ack) begin
                    push        = !miss && (!fifo_full || hit);
                    wb_cyc_next = 1'b0;
                    state_next  = IDLE;
                end else if (miss) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (wb.ack) begin
                    wb_cyc_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                wb_cyc_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            wb_cyc_reg   <= 1'b0;
            wb_adr_reg   <= '0;
            head_adr_reg <= '0;
            pf_adr_reg   <= '0;
            ack_reg      <= 1'b0;
            rdt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            wb_cyc_reg   <= wb_cyc_next;
            wb_adr_reg   <= wb_adr_next;
            head_adr_reg <= head_adr_next;
            pf_adr_reg   <= pf_adr_next;
            ack_reg      <= hit;
            if (hit) rdt_reg <= fifo_head;
        end
    end

    serv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (wb.rdt),
        .i_pop   (hit),
        .i_flush (miss),
        .o_data  (fifo_head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_count (fifo_count)
    );

    assign core.ack = ack_reg;
    assign core.rdt = rdt_reg;
    assign wb.cyc   = wb_cyc_reg;
    assign wb.adr   = wb_adr_reg;

`ifdef SERV_FETCH_BUF_PERF_EN
    logic [15:0] hit_cnt_reg;
    logic [15:0] miss_cnt_reg;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit && (hit_cnt_reg != 16'hFFFF))   hit_cnt_reg  <= hit_cnt_reg + 16'd1;
            if (miss && (miss_cnt_reg != 16'hFFFF)) miss_cnt_reg <= miss_cnt_reg + 16'd1;
        end
    end

    assign o_hit_cnt  = hit_cnt_reg;
    assign o_miss_cnt = miss_cnt_reg;
`endif

endmodule
